// File: rtl/ce_synth_pkg.sv
// Shared types and constants for the clock-enable synthesiser.
package ce_synth_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } ce_state_t;

    localparam int CH_IDX_W = 3;
    localparam int MAX_NCH  = 8;

endpackage

// File: rtl/ce_synth_chan.sv
// One phase-accumulator channel: accumulator, increment, registered carry pulse, square toggle.
module ce_synth_chan #(
    parameter int               ACC_W       = 32,
    parameter logic [ACC_W-1:0] INC_RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc_we,
    input  logic [ACC_W-1:0] i_inc,
    input  logic             i_sync,
    input  logic             i_lock_next,
    output logic             o_ce,
    output logic             o_sq
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic             r_ce;
    logic             r_sq;
    logic [ACC_W:0]   w_sum;
    logic             w_fire;

    assign w_sum  = {1'b0, r_acc} + {1'b0, r_inc};
    // A carry only becomes a pulse when the controller will be locked in the pulse cycle.
    assign w_fire = w_sum[ACC_W] & ~i_sync & i_lock_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
            r_inc <= INC_RST_VAL;
            r_ce  <= 1'b0;
            r_sq  <= 1'b0;
        end else begin
            if (i_inc_we) begin
                r_inc <= i_inc;
            end
            r_acc <= i_sync ? '0 : w_sum[ACC_W-1:0];
            r_ce  <= w_fire;
            r_sq  <= i_sync ? 1'b0 : (r_sq ^ w_fire);
        end
    end

    assign o_ce = r_ce;
    assign o_sq = r_sq;

endmodule

// File: rtl/ce_synth.sv
// Multi-channel clock-enable synthesiser with a settle/lock controller.
module ce_synth
    import ce_synth_pkg::*;
#(
    parameter int                     NCH         = 2,
    parameter int                     ACC_W       = 32,
    parameter int                     LOCK_CYCLES = 16,
    parameter logic [NCH*ACC_W-1:0]   INC_RST     = '0
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [ACC_W-1:0]    cfg_inc,
    input  logic                sync,
    output logic [NCH-1:0]      ce_out,
    output logic [NCH-1:0]      sq_out,
    output logic                locked
);

    localparam logic [7:0] LOCK_INIT = 8'(LOCK_CYCLES);

    ce_state_t  r_state;
    ce_state_t  w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       w_wr_valid;
    logic       w_lock_next;

    assign w_wr_valid  = cfg_we && ({1'b0, cfg_ch} < 4'(NCH));
    assign w_lock_next = (w_state_next == ST_LOCKED);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_RESET: begin
                w_state_next = ST_SETTLE;
                w_cnt_next   = LOCK_INIT;
            end
            ST_SETTLE: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = ST_LOCKED;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            ST_LOCKED: w_state_next = ST_LOCKED;
            default:   w_state_next = ST_RESET;
        endcase
        // Any accepted increment change restarts the settle window.
        if (w_wr_valid) begin
            w_state_next = ST_SETTLE;
            w_cnt_next   = LOCK_INIT;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state <= ST_RESET;
            r_cnt   <= LOCK_INIT;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign locked = (r_state == ST_LOCKED);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            ce_synth_chan #(
                .ACC_W       (ACC_W),
                .INC_RST_VAL (INC_RST[gi*ACC_W +: ACC_W])
            ) u_chan (
                .i_clk       (refclk),
                .i_rst       (rst),
                .i_inc_we    (w_wr_valid && (cfg_ch == CH_IDX_W'(gi))),
                .i_inc       (cfg_inc),
                .i_sync      (sync),
                .i_lock_next (w_lock_next),
                .o_ce        (ce_out[gi]),
                .o_sq        (sq_out[gi])
            );
        end
    endgenerate

endmodule
